// File: rtl/risc_v_ctrl_decode.sv
// ---------------------------------------------------------------------------
// risc_v_ctrl_decode
//   Main control decode for a single-issue RISC-V pipeline. This block decodes
//   the opcode and ALU function fields of the instruction, together with the
//   two PC adders that follow the fetch stage. Every output is registered, so
//   results appear one clock edge after the inputs are presented.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low; clears every output register
//   stall          1 = all output registers hold their current value
//   instruction    32-bit instruction word
//   pc             current program counter (XLEN)
//   imm_data       sign-extended immediate (XLEN)
//   Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite
//                  registered single-bit control flags
//   ALUOp          registered ALU operation class (2)
//   Operation      registered ALU operation code (4)
//   pc_plus4       registered pc + 4, wrapping modulo 2^XLEN
//   branch_target  registered pc + (imm_data << 1), wrapping modulo 2^XLEN
// ---------------------------------------------------------------------------
module risc_v_ctrl_decode #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm_data,
    output logic            Branch,
    output logic            MemRead,
    output logic            MemtoReg,
    output logic            MemWrite,
    output logic            ALUSrc,
    output logic            RegWrite,
    output logic [1:0]      ALUOp,
    output logic [3:0]      Operation,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] branch_target
);

    // Major opcodes this block recognises
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // Control bundle, ordered as it is listed in the decode table below
    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    logic [6:0]      opcode;
    logic [3:0]      funct;
    ctrl_t           ctrl_d;
    logic [3:0]      operation_d;
    logic [XLEN-1:0] pc_plus4_d;
    logic [XLEN-1:0] branch_target_d;

    assign opcode = instruction[6:0];
    assign funct  = {instruction[30], instruction[14:12]};

    // Register, immediate and upper funct7 fields are decoded elsewhere.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

    // ------------------------------------------------------------------
    // Main control decode. Unknown opcodes fall through to all-zero so a
    // junk instruction can never write memory or the register file.
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_d = CTRL_NONE;
        unique case (opcode)
            //                 src   m2r   regw  mrd   mwr   br    aluop
            OP_RTYPE:  ctrl_d = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
            OP_LOAD:   ctrl_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
            OP_STORE:  ctrl_d = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
            OP_BRANCH: ctrl_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
            OP_ITYPE:  ctrl_d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
            default:   ctrl_d = CTRL_NONE;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU control. Only the R-type class looks at Funct; everything not
    // explicitly listed (including ALUOp 11) resolves to add.
    // ------------------------------------------------------------------
    always_comb begin
        operation_d = ALU_ADD;
        case (ctrl_d.alu_op)
            2'b00: operation_d = ALU_ADD;
            2'b01: operation_d = ALU_SUB;
            2'b10: begin
                case (funct)
                    4'b0000: operation_d = ALU_ADD;
                    4'b1000: operation_d = ALU_SUB;
                    4'b0111: operation_d = ALU_AND;
                    4'b0110: operation_d = ALU_OR;
                    default: operation_d = ALU_ADD;
                endcase
            end
            default: operation_d = ALU_ADD;
        endcase
    end

    // ------------------------------------------------------------------
    // PC adders. Both wrap modulo 2^XLEN; the shifted immediate drops its
    // top bit, and negative immediates subtract through two's complement.
    // ------------------------------------------------------------------
    assign pc_plus4_d      = pc + XLEN'(4);
    assign branch_target_d = pc + (imm_data << 1);

    // ------------------------------------------------------------------
    // Output registers. Reset wins over stall and clears everything at
    // once, so a decode in flight when reset arrives is simply dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Branch        <= 1'b0;
            MemRead       <= 1'b0;
            MemtoReg      <= 1'b0;
            MemWrite      <= 1'b0;
            ALUSrc        <= 1'b0;
            RegWrite      <= 1'b0;
            ALUOp         <= 2'b00;
            Operation     <= 4'b0000;
            pc_plus4      <= '0;
            branch_target <= '0;
        end else if (!stall) begin
            Branch        <= ctrl_d.branch;
            MemRead       <= ctrl_d.mem_read;
            MemtoReg      <= ctrl_d.mem_to_reg;
            MemWrite      <= ctrl_d.mem_write;
            ALUSrc        <= ctrl_d.alu_src;
            RegWrite      <= ctrl_d.reg_write;
            ALUOp         <= ctrl_d.alu_op;
            Operation     <= operation_d;
            pc_plus4      <= pc_plus4_d;
            branch_target <= branch_target_d;
        end
    end

endmodule

// File: tb/tb_risc_v_ctrl_decode.sv
// ---------------------------------------------------------------------------
// tb_risc_v_ctrl_decode
//   Self-checking bench for risc_v_ctrl_decode (XLEN = 64). Directed cases
//   cover the reference instructions, wrap-around, unknown opcode, async
//   reset and stall; a randomized run is checked against a reference model
//   computed from the decode table with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_risc_v_ctrl_decode;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall;
    logic [31:0]     instruction;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm_data;
    logic            Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [1:0]      ALUOp;
    logic [3:0]      Operation;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] branch_target;

    risc_v_ctrl_decode #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .instruction   (instruction),
        .pc            (pc),
        .imm_data      (imm_data),
        .Branch        (Branch),
        .MemRead       (MemRead),
        .MemtoReg      (MemtoReg),
        .MemWrite      (MemWrite),
        .ALUSrc        (ALUSrc),
        .RegWrite      (RegWrite),
        .ALUOp         (ALUOp),
        .Operation     (Operation),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected register contents
    logic            e_br, e_mrd, e_m2r, e_mwr, e_src, e_rw;
    logic [1:0]      e_aluop;
    logic [3:0]      e_op;
    logic [XLEN-1:0] e_pc4, e_bt;

    task automatic exp_zero();
        {e_br, e_mrd, e_m2r, e_mwr, e_src, e_rw} = '0;
        e_aluop = 2'b00;
        e_op    = 4'b0000;
        e_pc4   = '0;
        e_bt    = '0;
    endtask

    // Reference model: classify the instruction by name, then apply the
    // architectural meaning of that class.
    task automatic model(input logic [31:0] ins, input logic [XLEN-1:0] p,
                         input logic [XLEN-1:0] im);
        string      kind;
        logic [2:0] f3;
        logic       alt;
        f3  = ins[14:12];
        alt = ins[30];
        case (ins[6:0])
            7'h33:   kind = "rtype";
            7'h03:   kind = "load";
            7'h23:   kind = "store";
            7'h63:   kind = "branch";
            7'h13:   kind = "itype";
            default: kind = "none";
        endcase
        e_rw    = (kind == "rtype" || kind == "load" || kind == "itype");
        e_src   = (kind == "load" || kind == "store" || kind == "itype");
        e_mrd   = (kind == "load");
        e_m2r   = (kind == "load");
        e_mwr   = (kind == "store");
        e_br    = (kind == "branch");
        e_aluop = (kind == "rtype") ? 2'b10 : (kind == "branch") ? 2'b01 : 2'b00;
        if (kind == "branch")
            e_op = 4'b0110;                                // compare by subtract
        else if (kind == "rtype" && f3 == 3'd0 && alt)
            e_op = 4'b0110;                                // sub
        else if (kind == "rtype" && f3 == 3'd7 && !alt)
            e_op = 4'b0000;                                // and
        else if (kind == "rtype" && f3 == 3'd6 && !alt)
            e_op = 4'b0001;                                // or
        else
            e_op = 4'b0010;                                // add
        e_pc4 = p + 64'd4;
        e_bt  = p + im * 64'd2;
    endtask

    task automatic chk1(input string tag, input logic [XLEN-1:0] got,
                        input logic [XLEN-1:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic check_all(input string tag);
        chk1({tag, ".Branch"},        64'(Branch),    64'(e_br));
        chk1({tag, ".MemRead"},       64'(MemRead),   64'(e_mrd));
        chk1({tag, ".MemtoReg"},      64'(MemtoReg),  64'(e_m2r));
        chk1({tag, ".MemWrite"},      64'(MemWrite),  64'(e_mwr));
        chk1({tag, ".ALUSrc"},        64'(ALUSrc),    64'(e_src));
        chk1({tag, ".RegWrite"},      64'(RegWrite),  64'(e_rw));
        chk1({tag, ".ALUOp"},         64'(ALUOp),     64'(e_aluop));
        chk1({tag, ".Operation"},     64'(Operation), 64'(e_op));
        chk1({tag, ".pc_plus4"},      pc_plus4,       e_pc4);
        chk1({tag, ".branch_target"}, branch_target,  e_bt);
    endtask

    // One decode cycle: drive on the falling edge, sample 1 ns after rising.
    task automatic step(input string tag, input logic [31:0] ins,
                        input logic [XLEN-1:0] p, input logic [XLEN-1:0] im,
                        input logic st);
        @(negedge clk);
        instruction = ins;
        pc          = p;
        imm_data    = im;
        stall       = st;
        if (!st) model(ins, p, im);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] ins;
        logic [XLEN-1:0] rp, ri;
        logic [6:0] ops [6];
        ops = '{7'h33, 7'h03, 7'h23, 7'h63, 7'h13, 7'h7F};

        reset = 1'b0; stall = 1'b0;
        instruction = 32'h0; pc = '0; imm_data = '0;
        #1;
        exp_zero();
        check_all("reset_init");

        @(negedge clk);
        reset = 1'b1;

        // Reference instructions
        step("add",  32'h003100B3, 64'h100, 64'h0, 1'b0);
        chk1("add.literal_Operation", 64'(Operation), 64'h2);
        chk1("add.literal_pc_plus4",  pc_plus4, 64'h104);
        step("sub",  32'h403100B3, 64'h104, 64'h4, 1'b0);
        chk1("sub.literal_Operation", 64'(Operation), 64'h6);
        step("and",  32'h003170B3, 64'h108, 64'h8, 1'b0);
        chk1("and.literal_Operation", 64'(Operation), 64'h0);
        step("or",   32'h003160B3, 64'h10C, 64'h1, 1'b0);
        chk1("or.literal_Operation",  64'(Operation), 64'h1);
        step("ld",   32'h00013083, 64'h110, 64'h10, 1'b0);
        step("sd",   32'h00113023, 64'h114, 64'h20, 1'b0);
        step("beq",  32'h00208463, 64'h200, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        chk1("beq.literal_target", branch_target, 64'h1F0);
        step("wrap", 32'h00A00093, 64'hFFFF_FFFF_FFFF_FFFC, 64'h2, 1'b0);
        chk1("wrap.literal_pc_plus4", pc_plus4, 64'h0);
        step("unknown", 32'h0000007F, 64'h300, 64'h7, 1'b0);

        // Stall across an instruction change: expectations untouched
        step("pre_stall", 32'h00013083, 64'h400, 64'h40, 1'b0);
        step("stall1",    32'h403100B3, 64'h800, 64'h99, 1'b1);
        step("stall2",    32'h00113023, 64'h900, 64'h11, 1'b1);
        step("unstall",   32'h00113023, 64'h900, 64'h11, 1'b0);

        // Async reset between edges, with stall high to show reset priority
        @(negedge clk);
        #2;
        stall = 1'b1;
        reset = 1'b0;
        #1;
        exp_zero();
        check_all("async_reset");
        @(posedge clk);
        #1;
        check_all("reset_held");
        @(negedge clk);
        reset = 1'b1;
        step("post_reset", 32'h403100B3, 64'h1000, 64'h3, 1'b0);

        // Randomized decode with occasional stall
        for (int i = 0; i < 300; i++) begin
            ins      = $urandom;
            ins[6:0] = ops[$urandom_range(0, 5)];
            rp       = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            ri       = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) ri = 64'($signed(32'($urandom_range(0, 4095)) - 32'd2048));
            step("rand", ins, rp, ri, ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
